// File: rtl/kbd_pkg.sv
// Shared constants for the tiny16 keyboard FIFO controller.
package kbd_pkg;

    // Default geometry
    localparam int unsigned KBD_DATA_W = 8;
    localparam int unsigned KBD_BUS_W  = 16;
    localparam int unsigned KBD_DEPTH  = 8;

    // Bit positions in the bus word at the default bus width
    localparam int unsigned ST_OVF   = KBD_BUS_W - 1;
    localparam int unsigned ST_FULL  = KBD_BUS_W - 2;
    localparam int unsigned ST_EMPTY = KBD_BUS_W - 3;
    localparam int unsigned DV_BIT   = KBD_BUS_W - 1;

endpackage

// File: rtl/kbd_sync_fifo.sv
// Generic single-clock FIFO with flush; storage is never reset.
module kbd_sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              push_ack_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

    // A full FIFO still accepts a push when the same cycle pops
    assign do_pop     = pop_i && !clr_i && !empty_o;
    assign do_push    = push_i && !clr_i && (!full_o || pop_i);
    assign push_ack_o = do_push;

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/kbd_fifo_ctrl.sv
// Keyboard input controller: buffers key codes and serves them on the CPU bus.
module kbd_fifo_ctrl
    import kbd_pkg::*;
#(
    parameter int unsigned DATA_W = KBD_DATA_W,
    parameter int unsigned BUS_W  = KBD_BUS_W,
    parameter int unsigned DEPTH  = KBD_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_strobe,
    input  logic [DATA_W-1:0] in,
    input  logic              out_en,
    input  logic              stat_en,
    input  logic              clr_en,
    output logic [BUS_W-1:0]  out,
    output logic              trigger,
    output logic              empty,
    output logic              full
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Package indices are relative to the default bus width; rebase onto BUS_W
    localparam int unsigned OVF_B   = ST_OVF + BUS_W - KBD_BUS_W;
    localparam int unsigned FULL_B  = ST_FULL + BUS_W - KBD_BUS_W;
    localparam int unsigned EMPTY_B = ST_EMPTY + BUS_W - KBD_BUS_W;
    localparam int unsigned DV_B    = DV_BIT + BUS_W - KBD_BUS_W;

    logic [DATA_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              push_ack;
    logic [BUS_W-1:0]  out_q, out_d;
    logic              trigger_q, trigger_d;
    logic              overflow_q, overflow_d;

    kbd_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_en),
        .push_i     (in_strobe),
        .pop_i      (out_en),
        .wdata_i    (in),
        .rdata_o    (fifo_rdata),
        .count_o    (fifo_count),
        .empty_o    (empty),
        .full_o     (full),
        .push_ack_o (push_ack)
    );

    // Bus word, trigger and sticky overflow; clear wins, data read beats status
    always_comb begin
        out_d      = out_q;
        trigger_d  = 1'b0;
        overflow_d = overflow_q;
        if (clr_en) begin
            out_d      = '0;
            overflow_d = 1'b0;
        end else begin
            trigger_d = push_ack;
            if (in_strobe && !push_ack) overflow_d = 1'b1;
            if (out_en) begin
                out_d = '0;
                if (!empty) begin
                    out_d[DV_B]         = 1'b1;
                    out_d[DATA_W-1:0]   = fifo_rdata;
                end
            end else if (stat_en) begin
                out_d              = '0;
                out_d[CNT_W-1:0]   = fifo_count;
                out_d[OVF_B]       = overflow_q;
                out_d[FULL_B]      = full;
                out_d[EMPTY_B]     = empty;
            end
        end
    end

    // Output and overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            trigger_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            trigger_q  <= trigger_d;
            overflow_q <= overflow_d;
        end
    end

    assign out     = out_q;
    assign trigger = trigger_q;

endmodule
